// File: rtl/rxdata_pkg.sv
// Shared types and ASCII constants for the rxdata hex-line parser.
package rxdata_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ZERO,
      PFX,
      DIG,
      DISCARD
   } state_t;

   localparam logic [7:0] CHR_CR   = 8'h0D;
   localparam logic [7:0] CHR_LF   = 8'h0A;
   localparam logic [7:0] CHR_0    = 8'h30;
   localparam logic [7:0] CHR_X_LO = 8'h78;
   localparam logic [7:0] CHR_X_UP = 8'h58;

   localparam logic [3:0] MAX_DIGITS = 4'd8;

   function automatic logic is_term(input logic [7:0] ch);
      return (ch == CHR_CR) || (ch == CHR_LF);
   endfunction

   function automatic logic is_prefix(input logic [7:0] ch);
      return (ch == CHR_X_LO) || (ch == CHR_X_UP);
   endfunction

endpackage

// File: rtl/rxdata_hexdecode.sv
// Combinational ASCII hex-digit classifier: flags 0-9/a-f/A-F and yields the nibble.
module hexdecode (
   input  logic [7:0] ascii,
   output logic       is_hex,
   output logic [3:0] nibble
);

   // Letters 'a'/'A' sit at xx1 in their low nibble, so adding 9 maps them to 10..15.
   always_comb begin
      is_hex = 1'b0;
      nibble = 4'h0;
      if ((ascii >= 8'h30) && (ascii <= 8'h39)) begin
         is_hex = 1'b1;
         nibble = ascii[3:0];
      end else if (((ascii >= 8'h41) && (ascii <= 8'h46)) ||
                   ((ascii >= 8'h61) && (ascii <= 8'h66))) begin
         is_hex = 1'b1;
         nibble = ascii[3:0] + 4'd9;
      end
   end

endmodule

// File: rtl/rxdata.sv
// Parses "0x" + 1..8 hex digits + CR/LF lines from rxuart into 32-bit words.
// Define RXDATA_BARE_HEX_EN to make the "0x" prefix optional.
module rxdata
   import rxdata_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_stb,
   input  logic [7:0]  i_byte,
   output logic        o_stb,
   output logic [31:0] o_data,
   output logic        o_err,
   output logic        o_busy
);

   state_t      state;
   logic [31:0] acc;
   logic [3:0]  count;
   logic        is_hex;
   logic [3:0]  nibble;
   logic        term;

   hexdecode u_hexdecode (
      .ascii  (i_byte),
      .is_hex (is_hex),
      .nibble (nibble)
   );

   assign term = is_term(i_byte);

   // o_busy is written alongside every state change so it always mirrors state != IDLE.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state  <= IDLE;
         acc    <= 32'h0;
         count  <= 4'd0;
         o_stb  <= 1'b0;
         o_err  <= 1'b0;
         o_data <= 32'h0;
         o_busy <= 1'b0;
      end else begin
         o_stb <= 1'b0;
         o_err <= 1'b0;
         if (i_stb) begin
            case (state)
               IDLE: begin
                  if (i_byte == CHR_0) begin
                     state  <= ZERO;
                     o_busy <= 1'b1;
                  end else if (term) begin
                     state  <= IDLE;
                     o_busy <= 1'b0;
`ifdef RXDATA_BARE_HEX_EN
                  end else if (is_hex) begin
                     state  <= DIG;
                     acc    <= {28'h0, nibble};
                     count  <= 4'd1;
                     o_busy <= 1'b1;
`endif
                  end else begin
                     state  <= DISCARD;
                     o_busy <= 1'b1;
                  end
               end

               ZERO: begin
                  if (is_prefix(i_byte)) begin
                     state  <= PFX;
                     o_busy <= 1'b1;
                  end else if (term) begin
                     state  <= IDLE;
                     o_busy <= 1'b0;
`ifdef RXDATA_BARE_HEX_EN
                     o_stb  <= 1'b1;
                     o_data <= 32'h0;
                  end else if (is_hex) begin
                     // The leading '0' already consumed one of the digit slots.
                     state  <= DIG;
                     acc    <= {28'h0, nibble};
                     count  <= 4'd2;
                     o_busy <= 1'b1;
`else
                     o_err  <= 1'b1;
`endif
                  end else begin
                     state  <= DISCARD;
                     o_busy <= 1'b1;
                  end
               end

               PFX: begin
                  if (is_hex) begin
                     state  <= DIG;
                     acc    <= {28'h0, nibble};
                     count  <= 4'd1;
                     o_busy <= 1'b1;
                  end else if (term) begin
                     state  <= IDLE;
                     o_err  <= 1'b1;
                     o_busy <= 1'b0;
                  end else begin
                     state  <= DISCARD;
                     o_busy <= 1'b1;
                  end
               end

               DIG: begin
                  if (is_hex && (count < MAX_DIGITS)) begin
                     acc    <= {acc[27:0], nibble};
                     count  <= count + 4'd1;
                     o_busy <= 1'b1;
                  end else if (term) begin
                     state  <= IDLE;
                     o_data <= acc;
                     o_stb  <= 1'b1;
                     o_busy <= 1'b0;
                  end else begin
                     state  <= DISCARD;
                     o_busy <= 1'b1;
                  end
               end

               DISCARD: begin
                  if (term) begin
                     state  <= IDLE;
                     o_err  <= 1'b1;
                     o_busy <= 1'b0;
                  end
               end

               default: begin
                  state  <= IDLE;
                  o_busy <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
